prefetch_buf: RTL and testbench

PREFETCH_BUF -- requirements
Module: prefetch_buf

---
 rtl/prefetch_buf_pkg.sv | 16 +
 rtl/prefetch_fifo.sv | 46 ++++
 rtl/prefetch_buf.sv | 108 ++++++++++
 tb/tb_prefetch_buf.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/prefetch_buf_pkg.sv
// Shared prefetch definitions: FSM encoding and default widths.
// Imported by the prefetch queue and its storage.
package prefetch_buf_pkg;

   typedef enum logic [0:0] {
      RUN    = 1'b0,
      HALTED = 1'b1
   } pf_state_t;

   localparam int PF_PC_WIDTH     = 12;
   localparam int PF_PMEM_WIDTH   = 16;
   localparam int PF_PC_INCREMENT = 2;
   localparam int PF_DEPTH        = 4;
   localparam int PF_RESET_PC     = 0;

endpackage

// File: rtl/prefetch_fifo.sv
// Circular {instr,pc} store with push/pop/flush and occupancy count.
// Entries are cleared on reset so the head reads zero when idle.
module prefetch_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 28
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic                         flush,
   input  logic                         push,
   input  logic                         pop,
   input  logic [WIDTH-1:0]             push_data,
   output logic [WIDTH-1:0]             head_data,
   output logic [$clog2(DEPTH+1)-1:0]   count
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    head;
   logic [AW-1:0]    tail;

   assign head_data = mem[head];

   always_ff @(posedge clock) begin
      if (reset) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (flush) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (push) begin
            mem[tail] <= push_data;
            tail      <= tail + 1'b1;
         end
         if (pop) head <= head + 1'b1;
         if (push && !pop)      count <= count + 1'b1;
         else if (pop && !push) count <= count - 1'b1;
      end
   end

endmodule

// File: rtl/prefetch_buf.sv
// Instruction prefetch queue: credit-limited pmem reads, redirect
// flush, halt, and a registered {instr,pc} head for fetch.
module prefetch_buf
   import prefetch_buf_pkg::*;
#(
   parameter int PC_WIDTH     = PF_PC_WIDTH,
   parameter int PMEM_WIDTH   = PF_PMEM_WIDTH,
   parameter int PC_INCREMENT = PF_PC_INCREMENT,
   parameter int DEPTH        = PF_DEPTH,
   parameter int RESET_PC     = PF_RESET_PC
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic                         in_set_pc,
   input  logic [PC_WIDTH-1:0]          in_branch_pc,
   input  logic                         in_halt,
   input  logic [PMEM_WIDTH-1:0]        in_pmem_word,
   output logic [PC_WIDTH-1:0]          out_pmem_addr,
   output logic                         out_pmem_rd_en,
   input  logic                         in_ready,
   output logic                         out_valid,
   output logic [PMEM_WIDTH-1:0]        out_instr,
   output logic [PC_WIDTH-1:0]          out_pc,
   output logic [$clog2(DEPTH+1)-1:0]   out_count
);

   localparam int CW = $clog2(DEPTH+1);
   localparam int EW = PMEM_WIDTH + PC_WIDTH;
   localparam logic [PC_WIDTH-1:0] RST_PC = PC_WIDTH'(RESET_PC);
   localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

   pf_state_t state, state_nx;

   logic [PC_WIDTH-1:0] fetch_pc;
   logic [PC_WIDTH-1:0] inflight_pc;
   logic [PC_WIDTH-1:0] issue_addr;
   logic                inflight;
   logic                issue;
   logic                credit;
   logic                push;
   logic                pop;
   logic [EW-1:0]       head;
   logic [CW:0]         occupancy;

   // Queued plus in-flight words must leave room, so a push never overflows.
   assign occupancy = {1'b0, out_count} + {{CW{1'b0}}, inflight};
   assign credit    = occupancy < DEPTH_W;

   assign issue_addr     = in_set_pc ? in_branch_pc : fetch_pc;
   assign out_pmem_addr  = reset ? RST_PC : issue_addr;
   assign out_pmem_rd_en = issue && !reset;

   assign out_valid = !reset && (out_count != '0) && !in_set_pc;
   assign out_instr = reset ? '0 : head[EW-1:PC_WIDTH];
   assign out_pc    = reset ? '0 : head[PC_WIDTH-1:0];

   assign push = inflight && !in_set_pc;
   assign pop  = out_valid && in_ready;

   always_comb begin
      state_nx = state;
      issue    = 1'b0;
      if (in_set_pc) begin
         state_nx = RUN;
         issue    = 1'b1;
      end else begin
         case (state)
            RUN: begin
               if (in_halt) state_nx = HALTED;
               else         issue    = credit;
            end
            HALTED:  state_nx = HALTED;
            default: state_nx = RUN;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state       <= RUN;
         fetch_pc    <= RST_PC;
         inflight    <= 1'b0;
         inflight_pc <= '0;
      end else begin
         state    <= state_nx;
         inflight <= issue;
         if (issue) begin
            inflight_pc <= issue_addr;
            fetch_pc    <= issue_addr + PC_WIDTH'(PC_INCREMENT);
         end
      end
   end

   prefetch_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (EW)
   ) u_fifo (
      .clock     (clock),
      .reset     (reset),
      .flush     (in_set_pc),
      .push      (push),
      .pop       (pop),
      .push_data ({in_pmem_word, inflight_pc}),
      .head_data (head),
      .count     (out_count)
   );

endmodule

// File: tb/tb_prefetch_buf.sv
// Bench for prefetch_buf: vector table, directed corner sequences,
// then random traffic against a queue-based reference model.
module tb_prefetch_buf;

   logic        clock;
   logic        reset;
   logic        in_set_pc;
   logic [11:0] in_branch_pc;
   logic        in_halt;
   logic [15:0] in_pmem_word;
   logic [11:0] out_pmem_addr;
   logic        out_pmem_rd_en;
   logic        in_ready;
   logic        out_valid;
   logic [15:0] out_instr;
   logic [11:0] out_pc;
   logic [2:0]  out_count;

   int vectors;
   int miscompares;

   prefetch_buf dut (
      .clock          (clock),
      .reset          (reset),
      .in_set_pc      (in_set_pc),
      .in_branch_pc   (in_branch_pc),
      .in_halt        (in_halt),
      .in_pmem_word   (in_pmem_word),
      .out_pmem_addr  (out_pmem_addr),
      .out_pmem_rd_en (out_pmem_rd_en),
      .in_ready       (in_ready),
      .out_valid      (out_valid),
      .out_instr      (out_instr),
      .out_pc         (out_pc),
      .out_count      (out_count)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Reference model: plain queue of delivered-to-be words.
   typedef struct packed {
      logic [15:0] instr;
      logic [11:0] pc;
   } ent_t;

   ent_t        mq[$];
   bit          m_infl;
   logic [11:0] m_infl_pc;
   logic [11:0] m_fetch;
   bit          m_halted;

   function automatic logic [15:0] word_of(logic [11:0] a);
      return {4'hA, a};
   endfunction

   function automatic bit m_issue();
      if (reset) return 1'b0;
      if (in_set_pc) return 1'b1;
      return !m_halted && !in_halt && (mq.size() + int'(m_infl) < 4);
   endfunction

   function automatic logic [11:0] m_addr();
      if (reset) return 12'h000;
      return in_set_pc ? in_branch_pc : m_fetch;
   endfunction

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   task automatic check_model();
      bit          e_rd;
      bit          e_val;
      logic [11:0] e_addr;
      logic [2:0]  e_cnt;
      ent_t        e_head;
      bit          bad;
      e_rd   = m_issue();
      e_addr = m_addr();
      e_val  = !reset && mq.size() != 0 && !in_set_pc;
      e_cnt  = 3'(mq.size());
      e_head = '0;
      if (e_val) e_head = mq[0];
      bad = (out_pmem_rd_en !== e_rd) || (out_pmem_addr !== e_addr)
         || (out_valid !== e_val) || (out_count !== e_cnt);
      if (e_val || reset)
         bad = bad || (out_instr !== e_head.instr) || (out_pc !== e_head.pc);
      vectors++;
      if (bad) begin
         miscompares++;
         $display("FAIL model t=%0t: rd %b/%b addr %h/%h vld %b/%b cnt %0d/%0d instr %h/%h pc %h/%h",
            $time, out_pmem_rd_en, e_rd, out_pmem_addr, e_addr, out_valid, e_val,
            out_count, e_cnt, out_instr, e_head.instr, out_pc, e_head.pc);
      end
   endtask

   task automatic update_model();
      bit          iss;
      bit          pop;
      bit          psh;
      logic [11:0] a;
      ent_t        e;
      if (reset) begin
         mq.delete();
         m_infl    = 1'b0;
         m_infl_pc = '0;
         m_fetch   = 12'h000;
         m_halted  = 1'b0;
      end else begin
         iss = m_issue();
         a   = m_addr();
         psh = m_infl && !in_set_pc;
         pop = mq.size() != 0 && !in_set_pc && in_ready;
         e.instr = word_of(m_infl_pc);
         e.pc    = m_infl_pc;
         if (in_set_pc) mq.delete();
         else begin
            if (pop) void'(mq.pop_front());
            if (psh) mq.push_back(e);
         end
         m_halted = in_set_pc ? 1'b0 : (in_halt ? 1'b1 : m_halted);
         m_infl   = iss;
         if (iss) begin
            m_infl_pc = a;
            m_fetch   = a + 12'd2;
         end
      end
   endtask

   task automatic sample();
      @(negedge clock);
      check_model();
   endtask

   // Pmem: returns the word for whatever address was presented at the edge.
   task automatic advance();
      logic [11:0] a;
      update_model();
      a = out_pmem_addr;
      @(posedge clock);
      #1;
      in_pmem_word = word_of(a);
   endtask

   task automatic step();
      sample();
      advance();
   endtask

   typedef struct {
      bit          rst;
      bit          set;
      bit          rdy;
      logic [11:0] br;
      bit          ev;
      logic [11:0] epc;
      logic [2:0]  ecnt;
      bit          erd;
      logic [11:0] eaddr;
   } row_t;

   function automatic row_t row(bit rst, bit set, bit rdy, logic [11:0] br,
      bit ev, logic [11:0] epc, logic [2:0] ec, bit erd, logic [11:0] ea);
      row_t r;
      r.rst = rst; r.set = set; r.rdy = rdy; r.br = br;
      r.ev = ev; r.epc = epc; r.ecnt = ec; r.erd = erd; r.eaddr = ea;
      return r;
   endfunction

   row_t        tbl[$];
   logic [11:0] wexp[3];
   int          delivered;

   initial begin
      vectors      = 0;
      miscompares  = 0;
      reset        = 1'b1;
      in_set_pc    = 1'b0;
      in_branch_pc = '0;
      in_halt      = 1'b0;
      in_ready     = 1'b1;
      in_pmem_word = '0;
      mq.delete();
      m_infl    = 1'b0;
      m_infl_pc = '0;
      m_fetch   = '0;
      m_halted  = 1'b0;

      // Reset release, back-to-back flow, stall to full, release, redirect.
      tbl.push_back(row(1, 0, 1, 0, 0, 12'h000, 0, 0, 12'h000));
      tbl.push_back(row(0, 0, 1, 0, 0, 12'h000, 0, 1, 12'h000));
      tbl.push_back(row(0, 0, 1, 0, 0, 12'h000, 0, 1, 12'h002));
      tbl.push_back(row(0, 0, 1, 0, 1, 12'h000, 1, 1, 12'h004));
      tbl.push_back(row(0, 0, 1, 0, 1, 12'h002, 1, 1, 12'h006));
      tbl.push_back(row(0, 0, 1, 0, 1, 12'h004, 1, 1, 12'h008));
      tbl.push_back(row(0, 0, 0, 0, 1, 12'h006, 1, 1, 12'h00A));
      tbl.push_back(row(0, 0, 0, 0, 1, 12'h006, 2, 1, 12'h00C));
      tbl.push_back(row(0, 0, 0, 0, 1, 12'h006, 3, 0, 12'h00E));
      for (int i = 0; i < 7; i++)
         tbl.push_back(row(0, 0, 0, 0, 1, 12'h006, 4, 0, 12'h00E));
      tbl.push_back(row(0, 0, 1, 0, 1, 12'h006, 4, 0, 12'h00E));
      tbl.push_back(row(0, 0, 0, 0, 1, 12'h008, 3, 1, 12'h00E));
      tbl.push_back(row(0, 0, 0, 0, 1, 12'h008, 3, 0, 12'h010));
      tbl.push_back(row(0, 1, 1, 12'h100, 0, 12'h000, 4, 1, 12'h100));
      tbl.push_back(row(0, 0, 1, 0, 0, 12'h000, 0, 1, 12'h102));
      tbl.push_back(row(0, 0, 1, 0, 1, 12'h100, 1, 1, 12'h104));
      tbl.push_back(row(0, 0, 1, 0, 1, 12'h102, 1, 1, 12'h106));

      foreach (tbl[i]) begin
         reset        = tbl[i].rst;
         in_set_pc    = tbl[i].set;
         in_ready     = tbl[i].rdy;
         in_branch_pc = tbl[i].br;
         sample();
         chk($sformatf("tbl%0d_valid", i), 32'(out_valid), 32'(tbl[i].ev));
         if (tbl[i].ev || tbl[i].rst)
            chk($sformatf("tbl%0d_pc", i), 32'(out_pc), 32'(tbl[i].epc));
         chk($sformatf("tbl%0d_count", i), 32'(out_count), 32'(tbl[i].ecnt));
         chk($sformatf("tbl%0d_rd_en", i), 32'(out_pmem_rd_en), 32'(tbl[i].erd));
         chk($sformatf("tbl%0d_addr", i), 32'(out_pmem_addr), 32'(tbl[i].eaddr));
         advance();
      end

      // PC wrap at the top of the address space.
      in_set_pc = 1'b1; in_branch_pc = 12'hFFC; in_ready = 1'b1;
      step();
      in_set_pc = 1'b0;
      step();
      wexp[0] = 12'hFFC; wexp[1] = 12'hFFE; wexp[2] = 12'h000;
      for (int k = 0; k < 3; k++) begin
         sample();
         chk("wrap_valid", 32'(out_valid), 32'd1);
         chk("wrap_pc", 32'(out_pc), 32'(wexp[k]));
         advance();
      end

      // Halt with two queued and one in flight.
      in_set_pc = 1'b1; in_branch_pc = 12'h200; in_ready = 1'b0;
      step();
      in_set_pc = 1'b0;
      step();
      step();
      in_halt = 1'b1;
      sample();
      chk("halt_cnt", 32'(out_count), 32'd2);
      chk("halt_no_issue", 32'(out_pmem_rd_en), 32'd0);
      advance();
      in_halt  = 1'b0;
      in_ready = 1'b1;
      delivered = 0;
      for (int k = 0; k < 8; k++) begin
         sample();
         if (out_valid && in_ready) delivered++;
         chk("halted_rd_en", 32'(out_pmem_rd_en), 32'd0);
         advance();
      end
      chk("halt_delivered", 32'(delivered), 32'd3);
      in_set_pc = 1'b1; in_branch_pc = 12'h040;
      sample();
      chk("resume_rd_en", 32'(out_pmem_rd_en), 32'd1);
      chk("resume_addr", 32'(out_pmem_addr), 32'h040);
      advance();
      in_set_pc = 1'b0;
      step();
      sample();
      chk("resume_valid", 32'(out_valid), 32'd1);
      chk("resume_pc", 32'(out_pc), 32'h040);
      advance();

      // Reset mid-operation with three entries queued.
      in_set_pc = 1'b1; in_branch_pc = 12'h300; in_ready = 1'b0;
      step();
      in_set_pc = 1'b0;
      step();
      step();
      step();
      reset = 1'b1;
      sample();
      chk("rst_pre_cnt", 32'(out_count), 32'd3);
      chk("rst_valid_low", 32'(out_valid), 32'd0);
      advance();
      reset = 1'b0;
      sample();
      chk("rst_post_cnt", 32'(out_count), 32'd0);
      chk("rst_post_valid", 32'(out_valid), 32'd0);
      chk("rst_post_rd_en", 32'(out_pmem_rd_en), 32'd1);
      chk("rst_post_addr", 32'(out_pmem_addr), 32'h000);
      advance();
      step();
      sample();
      chk("rst_first_pc", 32'(out_pc), 32'h000);
      chk("rst_first_valid", 32'(out_valid), 32'd1);
      advance();

      // Random traffic against the model.
      for (int k = 0; k < 600; k++) begin
         reset        = ($urandom_range(0, 99) < 2);
         in_set_pc    = ($urandom_range(0, 99) < 8);
         in_halt      = ($urandom_range(0, 99) < 6);
         in_ready     = 1'($urandom_range(0, 1));
         in_branch_pc = 12'($urandom) & 12'hFFE;
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
